// File: rtl/rect_painter_if.sv
// Command and image_ram write-port bundle between game logic (master) and rect_painter (slave).
interface rect_painter_if;
  logic       start;
  logic [7:0] x0;
  logic [6:0] y0;
  logic [7:0] w;
  logic [6:0] h;
  logic [2:0] color;
  logic       outline;
  logic [2:0] border_color;
  logic       we;
  logic [7:0] xw;
  logic [6:0] yw;
  logic [2:0] din;
  logic       busy;
  logic       done;

  modport master (
    output start, x0, y0, w, h, color, outline, border_color,
    input  we, xw, yw, din, busy, done
  );

  modport slave (
    input  start, x0, y0, w, h, color, outline, border_color,
    output we, xw, yw, din, busy, done
  );
endinterface

// File: rtl/rect_painter.sv
// Paints a clipped axis-aligned rectangle into image_ram, one pixel per clock,
// with an optional single-pixel border ring in a separate colour.
module rect_painter #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic           CLOCK_50,
  input  logic           reset,
  rect_painter_if.slave  bus
);
  // state | meaning
  // IDLE  | waiting for start
  // FILL  | emitting one pixel per clock
  // FIN   | one-cycle done pulse, start ignored
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [8:0] W_MAX = 9'(SCREEN_W);
  localparam logic [7:0] H_MAX = 8'(SCREEN_H);

  logic [1:0] r_state;
  logic [7:0] r_x0;
  logic [6:0] r_y0;
  logic [8:0] r_xe;
  logic [7:0] r_ye;
  logic [2:0] r_color;
  logic       r_outline;
  logic [2:0] r_border;
  logic       r_we;
  logic [7:0] r_xw;
  logic [6:0] r_yw;
  logic [2:0] r_din;
  logic       r_busy;
  logic       r_done;

  logic [8:0] w_sum_x;
  logic [7:0] w_sum_y;
  logic [8:0] w_xe;
  logic [7:0] w_ye;
  logic       w_empty;
  logic       w_x_last;
  logic       w_y_last;
  logic [7:0] w_nx;
  logic [6:0] w_ny;
  logic       w_fill_edge;

  // Exclusive end coordinates, clipped to the screen so nothing ever wraps.
  assign w_sum_x = {1'b0, bus.x0} + {1'b0, bus.w};
  assign w_sum_y = {1'b0, bus.y0} + {1'b0, bus.h};
  assign w_xe    = (w_sum_x > W_MAX) ? W_MAX : w_sum_x;
  assign w_ye    = (w_sum_y > H_MAX) ? H_MAX : w_sum_y;
  assign w_empty = (bus.w == 8'd0) || (bus.h == 7'd0) ||
                   ({1'b0, bus.x0} >= W_MAX) || ({1'b0, bus.y0} >= H_MAX);

  assign w_x_last = ({1'b0, r_xw} + 9'd1) >= r_xe;
  assign w_y_last = ({1'b0, r_yw} + 8'd1) >= r_ye;
  assign w_nx     = w_x_last ? r_x0 : r_xw + 8'd1;
  assign w_ny     = w_x_last ? r_yw + 7'd1 : r_yw;
  assign w_fill_edge = r_outline &&
                       ((w_nx == r_x0) || ({1'b0, w_nx} == r_xe - 9'd1) ||
                        (w_ny == r_y0) || ({1'b0, w_ny} == r_ye - 8'd1));

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_x0      <= '0;
      r_y0      <= '0;
      r_xe      <= '0;
      r_ye      <= '0;
      r_color   <= '0;
      r_outline <= 1'b0;
      r_border  <= '0;
      r_we      <= 1'b0;
      r_xw      <= '0;
      r_yw      <= '0;
      r_din     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_x0      <= bus.x0;
            r_y0      <= bus.y0;
            r_xe      <= w_xe;
            r_ye      <= w_ye;
            r_color   <= bus.color;
            r_outline <= bus.outline;
            r_border  <= bus.border_color;
            if (w_empty) begin
              r_state <= S_FIN;
              r_done  <= 1'b1;
            end else begin
              // The first pixel (x0,y0) always sits on the border ring.
              r_state <= S_FILL;
              r_we    <= 1'b1;
              r_busy  <= 1'b1;
              r_xw    <= bus.x0;
              r_yw    <= bus.y0;
              r_din   <= bus.outline ? bus.border_color : bus.color;
            end
          end
        end
        S_FILL: begin
          if (w_x_last && w_y_last) begin
            r_state <= S_FIN;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_xw  <= w_nx;
            r_yw  <= w_ny;
            r_din <= w_fill_edge ? r_border : r_color;
          end
        end
        S_FIN: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.we   = r_we;
  assign bus.xw   = r_xw;
  assign bus.yw   = r_yw;
  assign bus.din  = r_din;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
endmodule

// File: tb/tb_rect_painter.sv
// Scoreboard bench for rect_painter: directed cases plus random rectangles,
// expected pixels and done pulses come from a simple rectangle model.
module tb_rect_painter;
  typedef struct {
    int x;
    int y;
    int c;
    int cyc;
  } pix_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  pix_t pix_q[$];
  int   done_q[$];

  rect_painter_if bus ();

  rect_painter #(.SCREEN_W(160), .SCREEN_H(120)) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: every pixel of the clipped rectangle in row-major order, one per cycle from k.
  task automatic push_cmd(input int k, input int x0, input int y0, input int w, input int h,
                          input int c, input int o, input int b, output int n);
    int xe, ye;
    pix_t p;
    n = 0;
    if (w == 0 || h == 0 || x0 >= 160 || y0 >= 120) begin
      done_q.push_back(k);
      return;
    end
    xe = (x0 + w > 160) ? 160 : x0 + w;
    ye = (y0 + h > 120) ? 120 : y0 + h;
    for (int y = y0; y < ye; y++) begin
      for (int x = x0; x < xe; x++) begin
        p.x = x;
        p.y = y;
        p.c = (o != 0 && (x == x0 || x == xe - 1 || y == y0 || y == ye - 1)) ? b : c;
        p.cyc = k + n;
        pix_q.push_back(p);
        n++;
      end
    end
    done_q.push_back(k + n);
  endtask

  task automatic drive(input int x0, input int y0, input int w, input int h,
                       input int c, input int o, input int b);
    bus.x0 = 8'(x0);
    bus.y0 = 7'(y0);
    bus.w = 8'(w);
    bus.h = 7'(h);
    bus.color = 3'(c);
    bus.outline = 1'(o);
    bus.border_color = 3'(b);
  endtask

  task automatic scramble();
    drive($urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 255),
          $urandom_range(0, 127), $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7));
  endtask

  // Called right after a negedge; returns right after a negedge with the DUT idle again.
  task automatic send(input int x0, input int y0, input int w, input int h,
                      input int c, input int o, input int b, input int extra);
    int n;
    drive(x0, y0, w, h, c, o, b);
    bus.start = 1'b1;
    push_cmd(cyc + 1, x0, y0, w, h, c, o, b, n);
    @(negedge clk);
    bus.start = 1'b0;
    scramble();
    repeat (n + 1 + extra) @(negedge clk);
  endtask

  always @(negedge clk) begin
    pix_t p;
    if (!rst) begin
      chk("busy_vs_we", int'(bus.busy), int'(bus.we));
      while (pix_q.size() > 0 && pix_q[0].cyc < cyc) begin
        p = pix_q.pop_front();
        chk("missed_write_cycle", cyc, p.cyc);
      end
      while (done_q.size() > 0 && done_q[0] < cyc) begin
        chk("missed_done_cycle", cyc, done_q.pop_front());
      end
      if (bus.we) begin
        tests++;
        if (int'(bus.xw) >= 160 || int'(bus.yw) >= 120) begin
          fails++;
          $display("FAIL off_screen: wrote (%0d,%0d)", bus.xw, bus.yw);
        end
        tests++;
        if (pix_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_write: (%0d,%0d) din=%0d at cycle %0d, none expected",
                   bus.xw, bus.yw, bus.din, cyc);
        end else begin
          p = pix_q.pop_front();
          if (p.x != int'(bus.xw) || p.y != int'(bus.yw) || p.c != int'(bus.din) || p.cyc != cyc) begin
            fails++;
            $display("FAIL pixel: got (%0d,%0d) din=%0d cycle %0d, expected (%0d,%0d) din=%0d cycle %0d",
                     bus.xw, bus.yw, bus.din, cyc, p.x, p.y, p.c, p.cyc);
          end
        end
      end
      if (bus.done) begin
        tests++;
        if (bus.we) begin
          fails++;
          $display("FAIL done_with_we: done and we both high at cycle %0d", cyc);
        end
        if (done_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          chk("done_cycle", cyc, done_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got no end expected end");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n;
    bus.start = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_we", int'(bus.we), 0);
    chk("rst_xw", int'(bus.xw), 0);
    chk("rst_yw", int'(bus.yw), 0);
    chk("rst_din", int'(bus.din), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    send(10, 20, 3, 2, 5, 0, 0, 0);
    send(0, 0, 3, 3, 1, 1, 7, 1);
    send(158, 119, 4, 3, 0, 1, 2, 0);
    send(30, 30, 0, 5, 4, 0, 0, 0);
    send(200, 10, 5, 5, 4, 0, 0, 0);
    send(50, 60, 1, 4, 3, 1, 6, 0);
    send(50, 60, 5, 1, 3, 1, 6, 0);

    // start pulsed mid-fill must be ignored
    drive(40, 40, 4, 4, 2, 0, 0);
    bus.start = 1'b1;
    k = cyc + 1;
    push_cmd(k, 40, 40, 4, 4, 2, 0, 0, n);
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < k + 2) @(negedge clk);
    drive(0, 0, 2, 2, 7, 0, 0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < k + 17) @(negedge clk);

    // reset at the 5th write drops outputs immediately, no done follows
    drive(40, 40, 4, 4, 3, 1, 6);
    bus.start = 1'b1;
    k = cyc + 1;
    push_cmd(k, 40, 40, 4, 4, 3, 1, 6, n);
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < k + 4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_we", int'(bus.we), 0);
    chk("async_rst_busy", int'(bus.busy), 0);
    chk("async_rst_done", int'(bus.done), 0);
    pix_q.delete();
    done_q.delete();
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    send(12, 7, 3, 2, 1, 1, 4, 0);

    // start held high: accepted again the cycle after done (period N+2)
    drive(5, 5, 2, 1, 6, 0, 0);
    bus.start = 1'b1;
    k = cyc + 1;
    push_cmd(k, 5, 5, 2, 1, 6, 0, 0, n);
    push_cmd(k + 4, 5, 5, 2, 1, 6, 0, 0, n);
    repeat (8) @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      send($urandom_range(0, 170), $urandom_range(0, 125), $urandom_range(0, 20),
           $urandom_range(0, 12), $urandom_range(0, 7), $urandom_range(0, 1),
           $urandom_range(0, 7), $urandom_range(0, 2));
    end

    repeat (5) @(negedge clk);
    chk("pixels_outstanding", pix_q.size(), 0);
    chk("dones_outstanding", done_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
